// File: rtl/accum_cpu.sv
// Accumulator CPU: 1 instr/cycle from external program memory, internal RAM, OUT valid/ready handshake, HALT.
// Define ACCUM_CPU_MUL_EN to make opcode E a multiply (acc <- low bits of acc*M); otherwise E is a NOP.
module accum_cpu #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [ADDR_W+3:0] i_instr,
  input  logic              i_instr_valid,
  output logic [ADDR_W-1:0] o_pc,
  input  logic [DATA_W-1:0] i_data_in,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_zero,
  output logic              o_carry,
  output logic              o_halted
);

  localparam logic [3:0] OP_LDI = 4'h1, OP_LDM = 4'h2, OP_STM = 4'h3, OP_ADD = 4'h4,
                         OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7, OP_XOR = 4'h8,
                         OP_IN  = 4'h9, OP_OUT = 4'hA, OP_JMP = 4'hB, OP_JZ  = 4'hC,
                         OP_JC  = 4'hD, OP_MUL = 4'hE, OP_HLT = 4'hF;

  typedef enum logic [1:0] {S_RUN, S_OUT_WAIT, S_HALT} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_pc;
  logic [DATA_W-1:0]   r_acc;
  logic [DATA_W-1:0]   r_dout;
  logic                r_zero;
  logic                r_carry;
  logic [DATA_W-1:0]   r_mem [0:(1<<ADDR_W)-1];

  logic [3:0]          w_op;
  logic [ADDR_W-1:0]   w_opd;
  logic [DATA_W-1:0]   w_imm;
  logic [DATA_W-1:0]   w_m;
  logic [DATA_W:0]     w_sum;
  logic [DATA_W:0]     w_diff;
  logic [ADDR_W-1:0]   w_pc_inc;
  logic                w_exec;
  logic [ADDR_W-1:0]   w_pc_nxt;
  logic [DATA_W-1:0]   w_acc_nxt;
  logic                w_acc_we;
  logic                w_carry_nxt;
  logic                w_mem_we;
  logic                w_dout_we;

  assign w_op     = i_instr[ADDR_W+3:ADDR_W];
  assign w_opd    = i_instr[ADDR_W-1:0];
  assign w_imm    = DATA_W'(w_opd);
  assign w_m      = r_mem[w_opd];
  assign w_sum    = {1'b0, r_acc} + {1'b0, w_m};
  assign w_diff   = {1'b0, r_acc} - {1'b0, w_m};
  assign w_pc_inc = r_pc + ADDR_W'(1);
  assign w_exec   = (r_state == S_RUN) && i_instr_valid;

`ifdef ACCUM_CPU_MUL_EN
  logic [DATA_W-1:0] w_mul;
  assign w_mul = r_acc * w_m;
`endif

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_RUN;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN: begin
        if (w_exec && w_op == OP_OUT)      w_state_nxt = S_OUT_WAIT;
        else if (w_exec && w_op == OP_HLT) w_state_nxt = S_HALT;
      end
      S_OUT_WAIT: if (i_out_ready) w_state_nxt = S_RUN;
      S_HALT:     w_state_nxt = S_HALT;
      default:    w_state_nxt = S_RUN;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    o_out_valid = (r_state == S_OUT_WAIT);
    o_halted    = (r_state == S_HALT);
  end

  always_comb begin
    w_pc_nxt    = r_pc;
    w_acc_nxt   = r_acc;
    w_acc_we    = 1'b0;
    w_carry_nxt = r_carry;
    w_mem_we    = 1'b0;
    w_dout_we   = 1'b0;
    if (w_exec) begin
      w_pc_nxt = w_pc_inc;
      case (w_op)
        OP_LDI: begin w_acc_nxt = w_imm;         w_acc_we = 1'b1; end
        OP_LDM: begin w_acc_nxt = w_m;           w_acc_we = 1'b1; end
        OP_STM: w_mem_we = 1'b1;
        OP_ADD: begin
          w_acc_nxt   = w_sum[DATA_W-1:0];
          w_carry_nxt = w_sum[DATA_W];
          w_acc_we    = 1'b1;
        end
        // Top bit of the widened difference is the unsigned borrow.
        OP_SUB: begin
          w_acc_nxt   = w_diff[DATA_W-1:0];
          w_carry_nxt = w_diff[DATA_W];
          w_acc_we    = 1'b1;
        end
        OP_AND: begin w_acc_nxt = r_acc & w_m;   w_acc_we = 1'b1; end
        OP_OR:  begin w_acc_nxt = r_acc | w_m;   w_acc_we = 1'b1; end
        OP_XOR: begin w_acc_nxt = r_acc ^ w_m;   w_acc_we = 1'b1; end
        OP_IN:  begin w_acc_nxt = i_data_in;     w_acc_we = 1'b1; end
        OP_OUT: begin w_pc_nxt = r_pc;           w_dout_we = 1'b1; end
        OP_JMP: w_pc_nxt = w_opd;
        OP_JZ:  if (r_zero)  w_pc_nxt = w_opd;
        OP_JC:  if (r_carry) w_pc_nxt = w_opd;
`ifdef ACCUM_CPU_MUL_EN
        OP_MUL: begin w_acc_nxt = w_mul;         w_acc_we = 1'b1; end
`endif
        OP_HLT: w_pc_nxt = r_pc;
        default: ;
      endcase
    end else if (r_state == S_OUT_WAIT && i_out_ready) begin
      w_pc_nxt = w_pc_inc;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc    <= '0;
      r_acc   <= '0;
      r_dout  <= '0;
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
    end else begin
      r_pc    <= w_pc_nxt;
      r_carry <= w_carry_nxt;
      if (w_acc_we) begin
        r_acc  <= w_acc_nxt;
        r_zero <= (w_acc_nxt == '0);
      end
      if (w_dout_we) r_dout <= r_acc;
    end
  end

  // Data RAM has no reset; contents are undefined until written.
  always_ff @(posedge i_clk) begin
    if (w_mem_we && !i_reset) r_mem[w_opd] <= r_acc;
  end

  assign o_pc       = r_pc;
  assign o_data_out = r_dout;
  assign o_zero     = r_zero;
  assign o_carry    = r_carry;

endmodule

// File: tb/tb_accum_cpu.sv
// Directed bench for accum_cpu: expected status snapshots and output words are queued, a negedge monitor checks them.
// Define ACCUM_CPU_MUL_EN consistently for bench and RTL to select the opcode E expectation.
module tb_accum_cpu;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [11:0] i_instr;
  logic        i_instr_valid;
  logic [7:0]  o_pc;
  logic [7:0]  i_data_in;
  logic [7:0]  o_data_out;
  logic        o_out_valid;
  logic        i_out_ready;
  logic        o_zero;
  logic        o_carry;
  logic        o_halted;

  accum_cpu #(.DATA_W(8), .ADDR_W(8)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_instr(i_instr), .i_instr_valid(i_instr_valid),
    .o_pc(o_pc), .i_data_in(i_data_in), .o_data_out(o_data_out), .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready), .o_zero(o_zero), .o_carry(o_carry), .o_halted(o_halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         id;
    logic [7:0] pc;
    logic       z, c, h, ov;
    logic [7:0] d;
  } st_t;

  st_t        st_q[$];
  logic [7:0] out_q[$];
  int         cyc = 0;
  int         n_id = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: status snapshots by cycle, output words on each accepted transfer.
  always @(negedge clk) begin
    while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
      st_t s;
      s = st_q.pop_front();
      n_checks++;
      if (s.cyc != cyc || o_pc !== s.pc || o_zero !== s.z || o_carry !== s.c ||
          o_halted !== s.h || o_out_valid !== s.ov || o_data_out !== s.d) begin
        n_errors++;
        $display("FAIL status#%0d cyc=%0d: got pc=%h z=%b c=%b h=%b ov=%b dout=%h, want pc=%h z=%b c=%b h=%b ov=%b dout=%h (due cyc %0d)",
                 s.id, cyc, o_pc, o_zero, o_carry, o_halted, o_out_valid, o_data_out,
                 s.pc, s.z, s.c, s.h, s.ov, s.d, s.cyc);
      end
    end
    if (o_out_valid === 1'b1 && i_out_ready === 1'b1 && i_reset === 1'b0) begin
      n_checks++;
      if (out_q.size() == 0) begin
        n_errors++;
        $display("FAIL out_word: unexpected transfer of %h, none expected", o_data_out);
      end else begin
        logic [7:0] w;
        w = out_q.pop_front();
        if (o_data_out !== w) begin
          n_errors++;
          $display("FAIL out_word: got %h, want %h", o_data_out, w);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] opd);
    i_instr       = {op, opd};
    i_instr_valid = 1'b1;
  endtask

  // Expected status after the coming edge.
  task automatic exp(input logic [7:0] pc, input logic z, input logic c, input logic h,
                     input logic ov, input logic [7:0] d);
    st_t s;
    s.cyc = cyc + 1; s.id = n_id; s.pc = pc; s.z = z; s.c = c; s.h = h; s.ov = ov; s.d = d;
    n_id++;
    st_q.push_back(s);
  endtask

  // Run one instruction and expect pc/flags afterwards (not halted, no output pending).
  task automatic run(input logic [3:0] op, input logic [7:0] opd, input logic [7:0] pc,
                     input logic z, input logic c, input logic [7:0] d);
    issue(op, opd);
    exp(pc, z, c, 1'b0, 1'b0, d);
    tick();
  endtask

  // OUT with consumer ready: word appears one cycle later, transfers on the next edge.
  task automatic do_out(input logic [7:0] dat, input logic [7:0] pc, input logic z, input logic c);
    issue(4'hA, 8'h00);
    i_out_ready = 1'b1;
    out_q.push_back(dat);
    exp(pc, z, c, 1'b0, 1'b1, dat);
    tick();
    issue(4'h0, 8'h00);
    exp(pc + 8'd1, z, c, 1'b0, 1'b0, dat);
    tick();
  endtask

  initial begin
    logic [7:0] mul_res;
    i_reset = 1'b1; i_instr = '0; i_instr_valid = 1'b0; i_data_in = '0; i_out_ready = 1'b0;
    tick();
    exp(8'h00, 0, 0, 0, 0, 8'h00);
    tick();
    i_reset = 1'b0;
    exp(8'h00, 0, 0, 0, 0, 8'h00);
    tick();

    // Add without carry
    run(4'h1, 8'h05, 8'h01, 0, 0, 8'h00);
    run(4'h3, 8'h10, 8'h02, 0, 0, 8'h00);
    run(4'h1, 8'h03, 8'h03, 0, 0, 8'h00);
    run(4'h4, 8'h10, 8'h04, 0, 0, 8'h00);
    do_out(8'h08, 8'h04, 0, 0);

    // Add with carry-out to zero, then taken branches
    run(4'h1, 8'hFF, 8'h06, 0, 0, 8'h08);
    run(4'h3, 8'h00, 8'h07, 0, 0, 8'h08);
    run(4'h1, 8'h01, 8'h08, 0, 0, 8'h08);
    run(4'h4, 8'h00, 8'h09, 1, 1, 8'h08);
    run(4'hD, 8'h40, 8'h40, 1, 1, 8'h08);
    run(4'hC, 8'h80, 8'h80, 1, 1, 8'h08);
    do_out(8'h00, 8'h80, 1, 1);

    // SUB borrow, logic ops, untaken branches, IN
    run(4'h5, 8'h10, 8'h82, 0, 1, 8'h00);   // 00-05 = FB, borrow
    run(4'h5, 8'h10, 8'h83, 0, 0, 8'h00);   // FB-05 = F6
    run(4'hD, 8'h20, 8'h84, 0, 0, 8'h00);
    run(4'h6, 8'h10, 8'h85, 0, 0, 8'h00);   // F6&05 = 04
    run(4'h8, 8'h10, 8'h86, 0, 0, 8'h00);   // 04^05 = 01
    run(4'h7, 8'h00, 8'h87, 0, 0, 8'h00);   // 01|FF = FF
    run(4'hC, 8'h10, 8'h88, 0, 0, 8'h00);
    i_data_in = 8'h3C;
    run(4'h9, 8'h00, 8'h89, 0, 0, 8'h00);
    i_data_in = 8'h00;
    do_out(8'h3C, 8'h89, 0, 0);

    // STM then LDM of the same address
    run(4'h1, 8'h77, 8'h8B, 0, 0, 8'h3C);
    run(4'h3, 8'h20, 8'h8C, 0, 0, 8'h3C);
    run(4'h1, 8'h00, 8'h8D, 1, 0, 8'h3C);
    run(4'h2, 8'h20, 8'h8E, 0, 0, 8'h3C);
    do_out(8'h77, 8'h8E, 0, 0);

    // OUT under backpressure
    run(4'h1, 8'h2A, 8'h90, 0, 0, 8'h77);
    issue(4'hA, 8'h00);
    i_out_ready = 1'b0;
    out_q.push_back(8'h2A);
    exp(8'h90, 0, 0, 0, 1, 8'h2A);
    tick();
    for (int i = 0; i < 3; i++) begin
      issue(4'h1, 8'h11);
      exp(8'h90, 0, 0, 0, 1, 8'h2A);
      tick();
    end
    i_out_ready = 1'b1;
    exp(8'h91, 0, 0, 0, 0, 8'h2A);
    tick();

    // instr_valid low stalls everything
    run(4'h0, 8'h00, 8'h92, 0, 0, 8'h2A);
    issue(4'h1, 8'h00); i_instr_valid = 1'b0;
    exp(8'h92, 0, 0, 0, 0, 8'h2A);
    tick();
    issue(4'hB, 8'h00); i_instr_valid = 1'b0;
    exp(8'h92, 0, 0, 0, 0, 8'h2A);
    tick();
    do_out(8'h2A, 8'h92, 0, 0);

    // pc wrap
    run(4'hB, 8'hFF, 8'hFF, 0, 0, 8'h2A);
    run(4'h0, 8'h00, 8'h00, 0, 0, 8'h2A);
    run(4'h0, 8'h00, 8'h01, 0, 0, 8'h2A);

    // HALT freezes outputs
    issue(4'hF, 8'h00);
    exp(8'h01, 0, 0, 1, 0, 8'h2A);
    tick();
    for (int i = 0; i < 10; i++) begin
      issue(4'(i + 6), 8'(i * 7));
      i_out_ready = i[0];
      i_data_in   = 8'(i + 1);
      exp(8'h01, 0, 0, 1, 0, 8'h2A);
      tick();
    end
    i_reset = 1'b1; i_out_ready = 1'b0;
    exp(8'h00, 0, 0, 0, 0, 8'h00);
    tick();
    i_reset = 1'b0;

    // Reset in the middle of a handshake: no transfer
    run(4'h1, 8'h55, 8'h01, 0, 0, 8'h00);
    issue(4'hA, 8'h00);
    exp(8'h01, 0, 0, 0, 1, 8'h55);
    tick();
    i_reset = 1'b1;
    exp(8'h00, 0, 0, 0, 0, 8'h00);
    tick();
    i_reset = 1'b0;

    // Opcode E
`ifdef ACCUM_CPU_MUL_EN
    mul_res = 8'h2A;
`else
    mul_res = 8'h06;
`endif
    run(4'h1, 8'h07, 8'h01, 0, 0, 8'h00);
    run(4'h3, 8'h01, 8'h02, 0, 0, 8'h00);
    run(4'h1, 8'h06, 8'h03, 0, 0, 8'h00);
    run(4'hE, 8'h01, 8'h04, 0, 0, 8'h00);
    do_out(mul_res, 8'h04, 0, 0);

    i_instr_valid = 1'b0;
    tick();
    tick();
    n_checks++;
    if (st_q.size() != 0) begin
      n_errors++;
      $display("FAIL status_drain: %0d snapshots left, want 0", st_q.size());
    end
    n_checks++;
    if (out_q.size() != 0) begin
      n_errors++;
      $display("FAIL out_drain: %0d words never transferred, want 0", out_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/accum_cpu.md
# accum_cpu

Parametrised accumulator processor, the successor to the team's fixed 8-bit accumulator core. It fetches one instruction per cycle from an external program memory addressed by `pc` and operates on an internal data RAM. It adds zero/carry flags, conditional branches, an output handshake with backpressure, and a halt state. It sits between a program ROM/bus and a downstream consumer of `data_out` words.

## Interface
- `DATA_W`, 8, accumulator, data RAM word and I/O width (≥ 2)
- `ADDR_W`, 8, PC width and data RAM address width; RAM depth 2^ADDR_W (≥ 2)

- `clk`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; clears all state on the next rising edge
- `instr`  in  4+ADDR_W  `[ADDR_W+3:ADDR_W]` opcode, `[ADDR_W-1:0]` operand (address or immediate)
- `instr_valid`  in  1  `instr` holds the word at `pc`; low stalls the core
- `pc`  out  ADDR_W  program counter
- `data_in`  in  DATA_W  input port read by IN
- `data_out`  out  DATA_W  registered output word
- `out_valid`  out  1  `data_out` valid
- `out_ready`  in  1  consumer accepts `data_out`
- `zero`  out  1  accumulator == 0 (flag register)
- `carry`  out  1  carry/borrow from last ADD/SUB
- `halted`  out  1  core in HALT

## Operation
- States: RUN, OUT_WAIT, HALT. Reset → RUN.
- Reset clears `pc`, accumulator, `data_out`, `out_valid`, `zero`, `carry`, and `halted` to 0. Data RAM is not cleared; its contents are undefined until written.
- In RUN with `instr_valid`=1, execute by opcode (`op` = operand, imm = op zero-extended/truncated to DATA_W, M = RAM[op]):
  - 0 NOP; 1 LDI acc←imm; 2 LDM acc←M; 3 STM M←acc
  - 4 ADD acc←acc+M, carry←bit DATA_W of sum; 5 SUB acc←acc−M, carry←borrow (acc<M unsigned)
  - 6 AND; 7 OR; 8 XOR with M; 9 IN acc←`data_in`
  - A OUT: `data_out`←acc, `out_valid`←1, → OUT_WAIT, `pc` held
  - B JMP pc←op; C JZ pc←op if `zero` else pc+1; D JC pc←op if `carry` else pc+1
  - E MUL (see Configuration); F HLT → HALT, `halted`←1, `pc` held
- Every non-branch opcode other than OUT and HLT advances pc←pc+1. `pc` wraps from 2^ADDR_W−1 to 0.
- `zero` is updated to (new acc == 0) on every accumulator write; otherwise it is held. `carry` changes only on ADD/SUB.
- JZ/JC test flag values as held before the branch.
- In RUN with `instr_valid`=0: no state changes.
- OUT_WAIT: ignore `instr`. When `out_ready`=1: `out_valid`←0, pc←pc+1, → RUN. `data_out` holds its value until the next OUT.
- HALT: ignore all inputs except `reset`; outputs frozen.

## Timing
- One instruction per accepted cycle. Results (acc, flags, pc, RAM) are visible the cycle after the edge.
- LDM reads RAM combinationally. STM at edge N followed by LDM of the same address at edge N+1 returns the new value.
- OUT costs a minimum of 2 cycles: `out_valid` rises the cycle after issue, and the transfer completes on the first edge with `out_ready`=1.
- Reset asserted in any state, including OUT_WAIT mid-handshake or HALT, wins over all other activity at that edge. `out_valid` drops with no transfer.
- No combinational path from inputs to outputs.

## Configuration
- `ACCUM_CPU_MUL_EN` defined: opcode E executes MUL, acc←low DATA_W bits of acc×M, updates `zero`, leaves `carry` unchanged, and advances pc+1.
- Not defined: opcode E behaves exactly as NOP, and no multiplier is instantiated.

## Test plan
DATA_W=8, ADDR_W=8.
- Reset then LDI 0x05, STM 0x10, LDI 0x03, ADD 0x10 → acc=0x08, `zero`=0, `carry`=0, `pc`=4.
- LDI 0xFF, STM 0x00, LDI 0x01, ADD 0x00 → acc=0x00, `zero`=1, `carry`=1. JC 0x40 → `pc`=0x40. JZ 0x80 → `pc`=0x80.
- LDI 0x2A, OUT with `out_ready` low for 3 cycles → `out_valid`=1 and `data_out`=0x2A held, `pc` frozen. Raise `out_ready` → one-cycle transfer, `pc`+1.
- Drop `instr_valid` for 2 cycles mid-program → `pc`, acc, and flags unchanged. JMP 0xFF then NOP → `pc` wraps to 0x00.
- HLT → `halted`=1 with all outputs frozen for 10 cycles. Reset → all outputs 0, state RUN.
- LDI 0x07, STM 0x01, LDI 0x06, opcode E with operand 0x01 → acc=0x2A with macro defined; acc=0x06 and `pc`+1 without it.
